diagram_path_driver: RTL and testbench

//  Transmit-side companion to the 5-state diagram FSM (states A..E, 1-bit serial input, clock flux).

---
 rtl/diagram_path_driver.sv | 139 +++++++++++++
 tb/tb_diagram_path_driver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/diagram_path_driver.sv
// rtl/diagram_path_driver.sv - serial shortest-path driver for the 5-state diagram FSM
// Optional loopback state comparison: define LOOPBACK_CHECK_EN.
module diagram_path_driver #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       flux,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_target,
`ifdef LOOPBACK_CHECK_EN
  input  logic [4:0] obs_state,
  output logic       mismatch,
`endif
  output logic       req_ready,
  output logic       drv_in,
  output logic       drv_valid,
  output logic       done,
  output logic       err,
  output logic       busy,
  output logic [2:0] cur_state
);

  localparam logic [2:0] ST_A = 3'd0;
  localparam logic [2:0] ST_B = 3'd1;
  localparam logic [2:0] ST_C = 3'd2;
  localparam logic [2:0] ST_D = 3'd3;
  localparam logic [2:0] ST_E = 3'd4;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE, ERR} state_t;

  state_t     state, state_nx;
  logic [1:0] path_bits;
  logic [1:0] path_len;
  logic [3:0] hold_cnt;
  logic [1:0] lut_bits;
  logic [1:0] lut_len;
  logic       illegal;
  logic       hold_last;

  function automatic logic [2:0] step(input logic [2:0] s, input logic b);
    case (s)
      ST_A:    step = b ? ST_C : ST_B;
      ST_B:    step = b ? ST_D : ST_B;
      ST_C:    step = b ? ST_C : ST_E;
      ST_D:    step = b ? ST_C : ST_E;
      ST_E:    step = b ? ST_D : ST_B;
      default: step = ST_A;
    endcase
  endfunction

  // Path bits are stored first-bit-in-bit0 so SEND simply shifts right.
  always_comb begin
    lut_bits = 2'b00;
    lut_len  = 2'd0;
    case ({cur_state, req_target})
      {ST_A, ST_B}: begin lut_len = 2'd1; lut_bits = 2'b00; end
      {ST_A, ST_C}: begin lut_len = 2'd1; lut_bits = 2'b01; end
      {ST_A, ST_D}: begin lut_len = 2'd2; lut_bits = 2'b10; end
      {ST_A, ST_E}: begin lut_len = 2'd2; lut_bits = 2'b01; end
      {ST_B, ST_C}: begin lut_len = 2'd2; lut_bits = 2'b11; end
      {ST_B, ST_D}: begin lut_len = 2'd1; lut_bits = 2'b01; end
      {ST_B, ST_E}: begin lut_len = 2'd2; lut_bits = 2'b01; end
      {ST_C, ST_B}: begin lut_len = 2'd2; lut_bits = 2'b00; end
      {ST_C, ST_D}: begin lut_len = 2'd2; lut_bits = 2'b10; end
      {ST_C, ST_E}: begin lut_len = 2'd1; lut_bits = 2'b00; end
      {ST_D, ST_B}: begin lut_len = 2'd2; lut_bits = 2'b00; end
      {ST_D, ST_C}: begin lut_len = 2'd1; lut_bits = 2'b01; end
      {ST_D, ST_E}: begin lut_len = 2'd1; lut_bits = 2'b00; end
      {ST_E, ST_B}: begin lut_len = 2'd1; lut_bits = 2'b00; end
      {ST_E, ST_C}: begin lut_len = 2'd2; lut_bits = 2'b11; end
      {ST_E, ST_D}: begin lut_len = 2'd1; lut_bits = 2'b01; end
      default: ;
    endcase
  end

  // A has no incoming diagram edge, so it can only be requested while already there.
  assign illegal   = (req_target > ST_E) || (req_target == ST_A && cur_state != ST_A);
  assign hold_last = (hold_cnt == HOLD_LAST);

  always_ff @(posedge flux or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) begin
        if (illegal)             state_nx = ERR;
        else if (lut_len == 2'd0) state_nx = DONE;
        else                      state_nx = SEND;
      end
      SEND: if (hold_last && path_len == 2'd1) state_nx = DONE;
      DONE: state_nx = IDLE;
      ERR:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge flux or posedge reset) begin
    if (reset) begin
      cur_state <= ST_A;
      path_bits <= 2'b00;
      path_len  <= 2'd0;
      hold_cnt  <= 4'd0;
    end else if (state == IDLE) begin
      if (req_valid && !illegal) begin
        path_bits <= lut_bits;
        path_len  <= lut_len;
        hold_cnt  <= 4'd0;
      end
    end else if (state == SEND) begin
      if (hold_last) begin
        cur_state <= step(cur_state, path_bits[0]);
        path_bits <= path_bits >> 1;
        path_len  <= path_len - 2'd1;
        hold_cnt  <= 4'd0;
      end else begin
        hold_cnt  <= hold_cnt + 4'd1;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state == SEND);
  assign drv_valid = (state == SEND);
  assign drv_in    = (state == SEND) && path_bits[0];
  assign done      = (state == DONE);
  assign err       = (state == ERR);

`ifdef LOOPBACK_CHECK_EN
  always_ff @(posedge flux or posedge reset) begin
    if (reset) mismatch <= 1'b0;
    else if (obs_state != (5'b00001 << cur_state)) mismatch <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_diagram_path_driver.sv
// tb/tb_diagram_path_driver.sv - randomized model-checked bench for diagram_path_driver
module tb_diagram_path_driver;

  logic       flux = 1'b0;
  logic       reset = 1'b1;
  logic       rv  [2];
  logic [2:0] tgt [2];
  logic       rdy [2];
  logic       dv  [2];
  logic       din [2];
  logic       dn  [2];
  logic       er  [2];
  logic       bz  [2];
  logic [2:0] cs  [2];

  always #5 flux = ~flux;

`ifdef LOOPBACK_CHECK_EN
  logic [4:0] obs [2];
  logic       mm  [2];
  logic       force_obs = 1'b0;
  logic       mm_exp = 1'b0;
  logic       mm_pend = 1'b0;
  assign obs[0] = force_obs ? 5'b00100 : (5'b00001 << cs[0]);
  assign obs[1] = 5'b00001 << cs[1];
`endif

  diagram_path_driver #(.HOLD_CYCLES(1)) u_h1 (
    .flux(flux), .reset(reset), .req_valid(rv[0]), .req_target(tgt[0]),
`ifdef LOOPBACK_CHECK_EN
    .obs_state(obs[0]), .mismatch(mm[0]),
`endif
    .req_ready(rdy[0]), .drv_in(din[0]), .drv_valid(dv[0]), .done(dn[0]),
    .err(er[0]), .busy(bz[0]), .cur_state(cs[0])
  );

  diagram_path_driver #(.HOLD_CYCLES(3)) u_h3 (
    .flux(flux), .reset(reset), .req_valid(rv[1]), .req_target(tgt[1]),
`ifdef LOOPBACK_CHECK_EN
    .obs_state(obs[1]), .mismatch(mm[1]),
`endif
    .req_ready(rdy[1]), .drv_in(din[1]), .drv_valid(dv[1]), .done(dn[1]),
    .err(er[1]), .busy(bz[1]), .cur_state(cs[1])
  );

  typedef struct packed {
    logic       rdy, dv, din, dn, er, bz;
    logic [2:0] cs;
  } exp_t;

  exp_t       q [2][$];
  int         dir [2][$];
  logic [2:0] mcur [2];
  logic [2:0] cur_now [2];
  bit         cur_idle [2];
  int         hold_of [2] = '{1, 3};
  int         checks = 0;
  int         failures = 0;

  // Diagram edges; the bench finds paths by search rather than by table.
  function automatic logic [2:0] nxt(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    return b ? 3'd2 : 3'd1;
      3'd1:    return b ? 3'd3 : 3'd1;
      3'd2:    return b ? 3'd2 : 3'd4;
      3'd3:    return b ? 3'd2 : 3'd4;
      3'd4:    return b ? 3'd3 : 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  task automatic path_of(input logic [2:0] from, input logic [2:0] to,
                         output int len, output logic [1:0] bits);
    logic [2:0] s;
    logic [1:0] bb;
    len = -1;
    bits = 2'b00;
    if (from == to) begin
      len = 0;
      return;
    end
    for (int l = 1; l <= 2 && len < 0; l++) begin
      for (int v = 0; v < (1 << l) && len < 0; v++) begin
        s = from;
        bb = 2'b00;
        for (int i = 0; i < l; i++) begin
          bb[i] = v[l-1-i];
          s = nxt(s, bb[i]);
        end
        if (s == to) begin
          len = l;
          bits = bb;
        end
      end
    end
  endtask

  task automatic check_int(input int got, input int expv, input string nm);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, expv);
    end
  endtask

  task automatic accept(input int d, input logic [2:0] t);
    int         len;
    logic [1:0] bits;
    logic [2:0] s;
    if (t > 3'd4 || (t == 3'd0 && mcur[d] != 3'd0)) begin
      q[d].push_back('{rdy:0, dv:0, din:0, dn:0, er:1, bz:0, cs:mcur[d]});
      return;
    end
    path_of(mcur[d], t, len, bits);
    if (len < 0) begin
      check_int(len, 0, "model_path_found");
      return;
    end
    s = mcur[d];
    for (int i = 0; i < len; i++) begin
      for (int h = 0; h < hold_of[d]; h++)
        q[d].push_back('{rdy:0, dv:1, din:bits[i], dn:0, er:0, bz:1, cs:s});
      s = nxt(s, bits[i]);
    end
    q[d].push_back('{rdy:0, dv:0, din:0, dn:1, er:0, bz:0, cs:s});
    mcur[d] = s;
  endtask

  task automatic check_dut(input int d);
    exp_t e, a;
    if (q[d].size() > 0) begin
      e = q[d].pop_front();
      cur_idle[d] = 1'b0;
    end else begin
      e = '{rdy:1, dv:0, din:0, dn:0, er:0, bz:0, cs:mcur[d]};
      cur_idle[d] = 1'b1;
    end
    cur_now[d] = e.cs;
    a = {rdy[d], dv[d], din[d], dn[d], er[d], bz[d], cs[d]};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL outputs dut%0d t=%0t got rdy/dv/din/dn/er/bz/cs=%b exp=%b",
               d, $time, a, e);
    end
    checks++;
    if (dn[d] && er[d]) begin
      failures++;
      $display("FAIL done_err_overlap dut%0d t=%0t got=11 exp=not both", d, $time);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) check_dut(d);
`ifdef LOOPBACK_CHECK_EN
    if (mm_pend) mm_exp = 1'b1;
    mm_pend = 1'b0;
    checks++;
    if (mm[0] !== mm_exp || mm[1] !== 1'b0) begin
      failures++;
      $display("FAIL mismatch t=%0t got=%b%b exp=%b0", $time, mm[0], mm[1], mm_exp);
    end
`endif
  endtask

  task automatic tick(input bit rst_next, input bit do_force);
    bit was_reset;
    @(negedge flux);
    check_all();
    #1;
    was_reset = reset;
    reset = rst_next;
    if (rst_next) begin
      for (int d = 0; d < 2; d++) begin
        q[d].delete();
        mcur[d] = 3'd0;
      end
`ifdef LOOPBACK_CHECK_EN
      mm_exp = 1'b0;
      force_obs = 1'b0;
`endif
      if (!was_reset) begin
        #1;
        check_all();
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        rv[d]  = ($urandom_range(0, 2) == 0);
        tgt[d] = 3'($urandom_range(0, 7));
        if (dir[d].size() > 0 && cur_idle[d]) begin
          rv[d]  = 1'b1;
          tgt[d] = 3'(dir[d].pop_front());
        end
        if (rv[d] && cur_idle[d]) accept(d, tgt[d]);
      end
`ifdef LOOPBACK_CHECK_EN
      force_obs = do_force;
      mm_pend = force_obs && (cur_now[0] != 3'd2);
`endif
    end
  endtask

  initial begin
    int         len;
    logic [1:0] bits;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0;
      tgt[d] = 3'd0;
      mcur[d] = 3'd0;
      cur_now[d] = 3'd0;
      cur_idle[d] = 1'b1;
    end

    path_of(3'd0, 3'd3, len, bits);
    check_int(len, 2, "model_len_A_D");
    check_int(int'(bits), 2, "model_bits_A_D");
    path_of(3'd4, 3'd2, len, bits);
    check_int(int'(bits) + 4 * len, 11, "model_E_C");
    path_of(3'd2, 3'd1, len, bits);
    check_int(int'(bits) + 4 * len, 8, "model_C_B");
    path_of(3'd1, 3'd4, len, bits);
    check_int(int'(bits) + 4 * len, 9, "model_B_E");
    path_of(3'd3, 3'd3, len, bits);
    check_int(len, 0, "model_len_D_D");

    tick(1'b1, 1'b0);
    check_int(int'(rdy[0]) + 2 * int'(cs[0]) + 8 * int'(dv[0]), 1, "reset_state");
    tick(1'b1, 1'b0);

    dir[0] = '{3, 2, 1, 0, 6, 4, 4};
    dir[1] = '{3, 1};
    for (int c = 0; c < 800; c++) tick(1'b0, (c % 97) == 50);

    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    dir[0] = '{4};
    dir[1] = '{4};
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check_int(int'(bz[0]) + 2 * int'(dv[0]) + 4 * int'(cs[0]), 0, "reset_mid_send");
    tick(1'b1, 1'b0);
    for (int c = 0; c < 300; c++) tick(1'b0, (c % 61) == 30);
    tick(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
